at93c46_slave: RTL and testbench

AT93C46_SLAVE -- requirements
Module: at93c46_slave

---
 rtl/at93c46_slave.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_at93c46_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/at93c46_slave.sv
// AT93C46 (128x8) Microwire serial EEPROM slave emulated on a 128-byte array.
// All serial inputs are synchronised into CLK; program/erase is self-timed.
module at93c46_slave #(
    parameter logic [15:0] BUSY_CYCLES = 16'd1000,
    parameter logic [7:0]  INIT_BYTE   = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EEPROM_CS,
    input  logic       EEPROM_SK,
    input  logic       EEPROM_DI,
    output logic       EEPROM_DO,
    input  logic       LD_WE,
    input  logic [6:0] LD_ADDR,
    input  logic [7:0] LD_DATA,
    output logic       MEM_BUSY,
    output logic [2:0] DBG_STATE
);

    typedef enum logic [2:0] {
        IDLE, START, CMD, RD, WR_DATA, WAIT_CS, BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_WRITE, OP_ERASE, OP_ERAL, OP_WRAL
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        cs_meta_q, cs_sync_q, cs_prev_q;
    logic        sk_meta_q, sk_sync_q, sk_prev_q;
    logic        di_meta_q, di_sync_q;
    logic [7:0]  sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wen_q, wen_d;
    logic [7:0]  rd_sh_q, rd_sh_d;
    logic        rd_do_q, rd_do_d;
    logic [15:0] timer_q, timer_d;
    logic        done_q, done_d;
    logic        commit;

    logic        cs_rise, cs_fall, sk_rise;
    logic [8:0]  shift_new;
    logic [1:0]  dec_op;
    logic [6:0]  dec_addr;
    logic [6:0]  addr_inc;

    logic        wr_one, wr_all;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  mem_rd [128];

    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;
    assign sk_rise   = sk_sync_q & ~sk_prev_q;
    assign shift_new = {sr_q, di_sync_q};
    assign dec_op    = shift_new[8:7];
    assign dec_addr  = shift_new[6:0];
    assign addr_inc  = addr_q + 7'd1;

    // Byte storage: each byte is its own register so whole-array ERAL/WRAL is one cycle.
    for (genvar g = 0; g < 128; g++) begin : g_mem
        logic [7:0] byte_q = INIT_BYTE;
        always_ff @(posedge CLK) begin
            if (wr_all || (wr_one && (wr_addr == 7'(g)))) begin
                byte_q <= wr_data;
            end
        end
        assign mem_rd[g] = byte_q;
    end

    // Serial commit has priority over the backdoor port; reset never touches memory.
    always_comb begin
        wr_one  = 1'b0;
        wr_all  = 1'b0;
        wr_addr = addr_q;
        wr_data = data_q;
        if (commit && !RST) begin
            case (op_q)
                OP_WRITE: wr_one = 1'b1;
                OP_ERASE: begin
                    wr_one  = 1'b1;
                    wr_data = 8'hFF;
                end
                OP_ERAL: begin
                    wr_all  = 1'b1;
                    wr_data = 8'hFF;
                end
                OP_WRAL: wr_all = 1'b1;
                default: ;
            endcase
        end else if (LD_WE && !MEM_BUSY) begin
            wr_one  = 1'b1;
            wr_addr = LD_ADDR;
            wr_data = LD_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = wen_q;
        rd_sh_d = rd_sh_q;
        rd_do_d = rd_do_q;
        timer_d = timer_q;
        done_d  = done_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_rise) state_d = START;
            end
            START: begin
                if (cs_fall) begin
                    state_d = IDLE;
                end else if (sk_rise && di_sync_q) begin
                    state_d = CMD;
                    cnt_d   = 4'd0;
                    sr_d    = 8'd0;
                end
            end
            CMD: begin
                if (cs_fall) begin
                    state_d = IDLE;
                end else if (sk_rise) begin
                    sr_d  = shift_new[7:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd8) begin
                        cnt_d  = 4'd0;
                        addr_d = dec_addr;
                        data_d = 8'd0;
                        done_d = 1'b0;
                        op_d   = OP_NONE;
                        case (dec_op)
                            2'b10: begin
                                state_d = RD;
                                rd_do_d = 1'b0;
                                rd_sh_d = mem_rd[dec_addr];
                            end
                            2'b01: begin
                                state_d = WR_DATA;
                                op_d    = OP_WRITE;
                            end
                            2'b11: begin
                                state_d = WAIT_CS;
                                op_d    = OP_ERASE;
                            end
                            default: begin
                                case (dec_addr[6:5])
                                    2'b11: begin
                                        wen_d   = 1'b1;
                                        state_d = WAIT_CS;
                                    end
                                    2'b00: begin
                                        wen_d   = 1'b0;
                                        state_d = WAIT_CS;
                                    end
                                    2'b10: begin
                                        op_d    = OP_ERAL;
                                        state_d = WAIT_CS;
                                    end
                                    default: begin
                                        op_d    = OP_WRAL;
                                        state_d = WR_DATA;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            end
            RD: begin
                if (cs_fall) begin
                    state_d = IDLE;
                end else if (sk_rise) begin
                    rd_do_d = rd_sh_q[7];
                    if (cnt_q == 4'd7) begin
                        // D0 just went out: next byte follows with no dummy bit.
                        cnt_d   = 4'd0;
                        addr_d  = addr_inc;
                        rd_sh_d = mem_rd[addr_inc];
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        rd_sh_d = {rd_sh_q[6:0], 1'b0};
                    end
                end
            end
            WR_DATA: begin
                if (cs_fall) begin
                    if (done_q && wen_q) begin
                        commit  = 1'b1;
                        state_d = BUSY;
                        timer_d = 16'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sk_rise && !done_q) begin
                    data_d = {data_q[6:0], di_sync_q};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) done_d = 1'b1;
                end
            end
            WAIT_CS: begin
                if (cs_fall) begin
                    if (((op_q == OP_ERASE) || (op_q == OP_ERAL)) && wen_q) begin
                        commit  = 1'b1;
                        state_d = BUSY;
                        timer_d = 16'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY: begin
                if (timer_q == BUSY_CYCLES - 16'd1) begin
                    state_d = IDLE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            op_q      <= OP_NONE;
            cs_meta_q <= 1'b0;
            cs_sync_q <= 1'b0;
            cs_prev_q <= 1'b0;
            sk_meta_q <= 1'b0;
            sk_sync_q <= 1'b0;
            sk_prev_q <= 1'b0;
            di_meta_q <= 1'b0;
            di_sync_q <= 1'b0;
            sr_q      <= 8'd0;
            cnt_q     <= 4'd0;
            addr_q    <= 7'd0;
            data_q    <= 8'd0;
            wen_q     <= 1'b0;
            rd_sh_q   <= 8'd0;
            rd_do_q   <= 1'b0;
            timer_q   <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cs_meta_q <= EEPROM_CS;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            sk_meta_q <= EEPROM_SK;
            sk_sync_q <= sk_meta_q;
            sk_prev_q <= sk_sync_q;
            di_meta_q <= EEPROM_DI;
            di_sync_q <= di_meta_q;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wen_q     <= wen_d;
            rd_sh_q   <= rd_sh_d;
            rd_do_q   <= rd_do_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
        end
    end

    // DO idles high; it carries read data in RD and the ready/busy flag in BUSY.
    assign EEPROM_DO = ((state_q == BUSY) && cs_sync_q) ? 1'b0 :
                       (state_q == RD) ? rd_do_q : 1'b1;
    assign MEM_BUSY  = (state_q == BUSY);
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_at93c46_slave.sv
// Directed bench for at93c46_slave: a bit-banged Microwire master plus a
// byte scoreboard for read data and direct checks for busy/status behaviour.
module tb_at93c46_slave;

    localparam int BUSY_N = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, sk, di;
    logic       do_w;
    logic       ld_we;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       mem_busy;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    int   busy_n;
    logic do_mid, do_after, seen, dummy;

    at93c46_slave dut (
        .CLK       (clk),
        .RST       (rst),
        .EEPROM_CS (cs),
        .EEPROM_SK (sk),
        .EEPROM_DI (di),
        .EEPROM_DO (do_w),
        .LD_WE     (ld_we),
        .LD_ADDR   (ld_addr),
        .LD_DATA   (ld_data),
        .MEM_BUSY  (mem_busy),
        .DBG_STATE (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SK period: DI set up during SK low, DO sampled late in SK high.
    task automatic xfer_bit(input logic b, output logic o);
        di = b;
        repeat (6) @(negedge clk);
        sk = 1'b1;
        repeat (5) @(negedge clk);
        o = do_w;
        @(negedge clk);
        sk = 1'b0;
    endtask

    task automatic cs_up();
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_down();
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [6:0] addr, output logic last_o);
        logic o;
        xfer_bit(1'b1, o);
        xfer_bit(op[1], o);
        xfer_bit(op[0], o);
        for (int i = 6; i >= 0; i--) xfer_bit(addr[i], o);
        last_o = o;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b0, o);
            b[i] = o;
        end
    endtask

    // Reads nbytes from addr and pops one expected byte per received byte.
    task automatic read_seq(input string tag, input logic [6:0] addr, input int nbytes);
        logic       d;
        logic [7:0] b;
        logic [7:0] e;
        cs_up();
        send_frame(2'b10, addr, d);
        check({tag, "_dummy"}, d, 1'b0);
        for (int k = 0; k < nbytes; k++) begin
            recv_byte(b);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check($sformatf("%s_byte%0d", tag, k), b, e);
        end
        cs_down();
    endtask

    task automatic write_frame(input logic [1:0] op, input logic [6:0] addr,
                               input logic [7:0] data, input int nbits);
        logic d;
        cs_up();
        send_frame(op, addr, d);
        for (int i = 0; i < nbits; i++) xfer_bit(data[7-i], d);
    endtask

    task automatic simple_cmd(input logic [6:0] addr);
        logic d;
        cs_up();
        send_frame(2'b00, addr, d);
    endtask

    // Drop CS to commit, then hold CS high and poll status through the busy window.
    task automatic commit_busy(output int n, output logic mid, output logic after);
        int t;
        cs = 1'b0;
        t = 0;
        n = 0;
        mid = 1'b1;
        @(negedge clk);
        while (!mem_busy && t < 30) begin
            t++;
            @(negedge clk);
        end
        cs = 1'b1;
        while (mem_busy && n < 5000) begin
            n++;
            if (n == 500) mid = do_w;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        after = do_w;
        cs_down();
    endtask

    task automatic no_busy(output logic s);
        cs = 1'b0;
        s = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mem_busy) s = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        cs = 1'b0;
        sk = 1'b0;
        di = 1'b0;
        ld_we = 1'b0;
        ld_addr = 7'd0;
        ld_data = 8'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_do", do_w, 1'b1);
        check("rst_busy", mem_busy, 1'b0);
        check("rst_state", dbg_state, 3'd0);

        // Fresh array reads back the init byte.
        exp_q.push_back(8'hFF);
        read_seq("init_rd05", 7'h05, 1);

        // EWEN, then WRITE 0x05 = 0xA5 with busy polling.
        simple_cmd(7'h60);
        cs_down();
        write_frame(2'b01, 7'h05, 8'hA5, 8);
        commit_busy(busy_n, do_mid, do_after);
        check("wr_busy_len", busy_n, BUSY_N);
        check("wr_do_busy", do_mid, 1'b0);
        check("wr_do_ready", do_after, 1'b1);
        exp_q.push_back(8'hA5);
        read_seq("wr_rd05", 7'h05, 1);

        // EWDS blocks the next write.
        simple_cmd(7'h00);
        cs_down();
        write_frame(2'b01, 7'h05, 8'h3C, 8);
        no_busy(seen);
        check("ewds_nobusy", seen, 1'b0);
        exp_q.push_back(8'hA5);
        read_seq("ewds_rd05", 7'h05, 1);

        // Backdoor loads, then sequential read wrapping 0x7F -> 0x00.
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 7'h7F; ld_data = 8'h11;
        @(negedge clk);
        ld_addr = 7'h00; ld_data = 8'h22;
        @(negedge clk);
        ld_we = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        read_seq("wrap_rd7f", 7'h7F, 2);

        // Partial write frame aborts without touching the byte.
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 7'h10; ld_data = 8'h5A;
        @(negedge clk);
        ld_we = 1'b0;
        simple_cmd(7'h60);
        cs_down();
        write_frame(2'b01, 7'h10, 8'hC3, 5);
        no_busy(seen);
        check("partial_nobusy", seen, 1'b0);
        exp_q.push_back(8'h5A);
        read_seq("partial_rd10", 7'h10, 1);

        // ERAL clears every byte to FF.
        simple_cmd(7'h40);
        commit_busy(busy_n, do_mid, do_after);
        check("eral_busy_len", busy_n, BUSY_N);
        exp_q.push_back(8'hFF);
        read_seq("eral_rd10", 7'h10, 1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_seq("eral_rd7f", 7'h7F, 3);
        exp_q.push_back(8'hFF);
        read_seq("eral_rd05", 7'h05, 1);

        // Backdoor ignored while busy; reset mid-busy keeps the write, drops the latch.
        simple_cmd(7'h60);
        cs_down();
        write_frame(2'b01, 7'h20, 8'h77, 8);
        cs = 1'b0;
        for (int t = 0; t < 30 && !mem_busy; t++) @(negedge clk);
        check("r36_busy_start", mem_busy, 1'b1);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 7'h21; ld_data = 8'h99;
        @(negedge clk);
        ld_we = 1'b0;
        cs = 1'b1;
        repeat (50) @(negedge clk);
        check("r36_do_busy", do_w, 1'b0);
        check("r36_still_busy", mem_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r36_rst_busy", mem_busy, 1'b0);
        check("r36_rst_do", do_w, 1'b1);
        check("r36_rst_state", dbg_state, 3'd0);
        cs_down();
        write_frame(2'b01, 7'h22, 8'h44, 8);
        no_busy(seen);
        check("r36_latch_clr", seen, 1'b0);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_seq("r36_rd20", 7'h20, 3);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
